slice_alu_seq: RTL and testbench

SLICE_ALU_SEQ -- requirements
Module: slice_alu_seq

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_slice.sv | 57 +++++
 rtl/slice_alu_seq.sv | 147 ++++++++++++++
 tb/tb_slice_alu_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the bit-serial slice ALU.
package alu_pkg;

    localparam int unsigned SLICE_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_CLR = 3'b000,
        OP_BMA = 3'b001,
        OP_AMB = 3'b010,
        OP_ADD = 3'b011,
        OP_XOR = 3'b100,
        OP_OR  = 3'b101,
        OP_AND = 3'b110,
        OP_SET = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_arith(input op_e op);
        return op inside {OP_BMA, OP_AMB, OP_ADD};
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit ALU slice; carry/generate/propagate are raw and
// only meaningful for arithmetic opcodes.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE_W = SLICE_W_DEFAULT
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  op_e                i_op,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_f,
    output logic               o_cout,
    output logic               o_c_msb,
    output logic               o_g,
    output logic               o_p
);

    logic [SLICE_W-1:0] w_x;
    logic [SLICE_W-1:0] w_y;
    logic [SLICE_W:0]   w_sum;

    always_comb begin
        w_x = i_a;
        w_y = i_b;
        unique case (i_op)
            OP_BMA: begin
                w_x = i_b;
                w_y = ~i_a;
            end
            OP_AMB:  w_y = ~i_b;
            default: ;
        endcase
    end

    assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {{SLICE_W{1'b0}}, i_cin};
    assign o_cout  = w_sum[SLICE_W];
    // Carry into the MSB recovered from the MSB sum bit.
    assign o_c_msb = w_sum[SLICE_W-1] ^ w_x[SLICE_W-1] ^ w_y[SLICE_W-1];
    // x + y overflows with no carry-in exactly when x > ~y.
    assign o_g     = (w_x > ~w_y);
    assign o_p     = &(w_x ^ w_y);

    always_comb begin
        o_f = '0;
        unique case (i_op)
            OP_CLR:                 o_f = '0;
            OP_BMA, OP_AMB, OP_ADD: o_f = w_sum[SLICE_W-1:0];
            OP_XOR:                 o_f = i_a ^ i_b;
            OP_OR:                  o_f = i_a | i_b;
            OP_AND:                 o_f = i_a & i_b;
            OP_SET:                 o_f = '1;
            default:                o_f = '0;
        endcase
    end

endmodule

// File: rtl/slice_alu_seq.sv
// Sequential ALU: latches an operation, processes one slice per cycle LSB
// first, then presents the full-width result with a valid/ready handshake.
module slice_alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned SLICES  = 4,
    parameter int unsigned SLICE_W = SLICE_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SLICES*SLICE_W-1:0] a,
    input  logic [SLICES*SLICE_W-1:0] b,
    input  logic [2:0]                s,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SLICES*SLICE_W-1:0] f,
    output logic                      cout,
    output logic                      ovf,
    output logic                      zero,
    output logic                      g,
    output logic                      p
);

    localparam int unsigned W        = SLICES * SLICE_W;
    localparam int unsigned IDX_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_e           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    op_e              r_op;
    logic             r_carry;
    logic             r_g;
    logic             r_p;

    logic [W-1:0]     r_f;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_go;
    logic             r_po;

    logic               w_accept;
    logic               w_last;
    logic               w_arith;
    logic [SLICE_W-1:0] w_slice_f;
    logic               w_cout;
    logic               w_c_msb;
    logic               w_sg;
    logic               w_sp;
    logic [W-1:0]       w_res_next;
    logic               w_g_next;
    logic               w_p_next;

    alu_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .i_a     (r_a[SLICE_W-1:0]),
        .i_b     (r_b[SLICE_W-1:0]),
        .i_op    (r_op),
        .i_cin   (r_carry),
        .o_f     (w_slice_f),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb),
        .o_g     (w_sg),
        .o_p     (w_sp)
    );

    assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_arith  = is_arith(r_op);

    // New slice enters at the top; after SLICES shifts the word is aligned.
    assign w_res_next = (r_res >> SLICE_W) | (W'(w_slice_f) << (W - SLICE_W));
    assign w_g_next   = w_sg | (w_sp & r_g);
    assign w_p_next   = w_sp & r_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_op    <= OP_CLR;
            r_carry <= 1'b0;
            r_g     <= 1'b0;
            r_p     <= 1'b0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_go    <= 1'b0;
            r_po    <= 1'b0;
        end else if (w_accept) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_op    <= op_e'(s);
            r_carry <= cin;
            r_g     <= 1'b0;
            r_p     <= 1'b1;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_g     <= w_g_next;
                    r_p     <= w_p_next;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_f     <= w_res_next;
                        r_zero  <= (w_res_next == '0);
                        r_cout  <= w_arith & w_cout;
                        r_ovf   <= w_arith & (w_c_msb ^ w_cout);
                        r_go    <= w_arith & w_g_next;
                        r_po    <= w_arith & w_p_next;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_state <= ST_IDLE;
                end
                ST_IDLE: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign f         = r_f;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign g         = r_go;
    assign p         = r_po;

endmodule

// File: tb/tb_slice_alu_seq.sv
// Scoreboard bench for slice_alu_seq: a 4-slice and a 1-slice instance.
module tb_slice_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv0, ir0, ov0, or0, cin0, cout0, ovf0, zero0, g0, p0;
    logic [15:0] a0, b0, f0;
    logic [2:0]  s0;

    logic        iv1, ir1, ov1, or1, cin1, cout1, ovf1, zero1, g1, p1;
    logic [3:0]  a1, b1, f1;
    logic [2:0]  s1;

    slice_alu_seq #(.SLICES(4), .SLICE_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .s(s0),
        .cin(cin0), .out_valid(ov0), .out_ready(or0), .f(f0), .cout(cout0), .ovf(ovf0),
        .zero(zero0), .g(g0), .p(p0)
    );

    slice_alu_seq #(.SLICES(1), .SLICE_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .s(s1),
        .cin(cin1), .out_valid(ov1), .out_ready(or1), .f(f1), .cout(cout1), .ovf(ovf1),
        .zero(zero1), .g(g1), .p(p1)
    );

    typedef struct {
        logic [15:0] f;
        logic [4:0]  flags;  // {cout, ovf, zero, g, p}
        int          due;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic seen0 = 1'b0;
    logic seen1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got out_valid=1 expected no result", name);
    endtask

    always @(negedge clk) begin
        if (ov0 === 1'b1 && !seen0) begin
            seen0 = 1'b1;
            if (q0.size() == 0) flag_fail("dut0.spurious_valid");
            else chk({"dut0.latency.", q0[0].name}, cyc, q0[0].due);
        end
        if (ov0 === 1'b1 && or0 === 1'b1) begin
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk({"dut0.f.", e0.name}, 32'(f0), 32'(e0.f));
                chk({"dut0.flags.", e0.name}, 32'({cout0, ovf0, zero0, g0, p0}), 32'(e0.flags));
            end
            seen0 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (ov1 === 1'b1 && !seen1) begin
            seen1 = 1'b1;
            if (q1.size() == 0) flag_fail("dut1.spurious_valid");
            else chk({"dut1.latency.", q1[0].name}, cyc, q1[0].due);
        end
        if (ov1 === 1'b1 && or1 === 1'b1) begin
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                chk({"dut1.f.", e1.name}, 32'(f1), 32'(e1.f));
                chk({"dut1.flags.", e1.name}, 32'({cout1, ovf1, zero1, g1, p1}), 32'(e1.flags));
            end
            seen1 = 1'b0;
        end
    end

    // Caller is just after a rising edge; returns just after the accept edge.
    task automatic issue(input int which, input string name, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] s, input logic c,
                         input logic [15:0] ef, input logic [4:0] eflags, input bit push);
        int   n = 0;
        exp_t e;
        if (which == 0) begin
            a0 = a; b0 = b; s0 = s; cin0 = c; iv0 = 1'b1;
        end else begin
            a1 = a[3:0]; b1 = b[3:0]; s1 = s; cin1 = c; iv1 = 1'b1;
        end
        #1;
        while (((which == 0) ? ir0 : ir1) !== 1'b1 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept.%s: got in_ready=0 for %0d cycles expected acceptance", name, n);
        end
        if (push) begin
            e.f = ef; e.flags = eflags; e.name = name;
            e.due = cyc + 1 + ((which == 0) ? 4 : 1);
            if (which == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(posedge clk); #1;
        // Scramble inputs so only latched operands can produce the result.
        if (which == 0) begin
            iv0 = 1'b0; a0 = ~a; b0 = ~b; s0 = ~s; cin0 = ~c;
        end else begin
            iv1 = 1'b0; a1 = ~a[3:0]; b1 = ~b[3:0]; s1 = ~s; cin1 = ~c;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain.%s: got %0d pending expected 0", name, q0.size() + q1.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        iv0 = 1'b0; a0 = '0; b0 = '0; s0 = '0; cin0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; s1 = '0; cin1 = 1'b0; or1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.in_ready0", 32'(ir0), 32'd1);
        chk("reset.out_valid0", 32'(ov0), 32'd0);
        chk("reset.f0", 32'(f0), 32'd0);
        chk("reset.flags0", 32'({cout0, ovf0, zero0, g0, p0}), 32'd0);
        chk("reset.in_ready1", 32'(ir1), 32'd1);
        chk("reset.out1", 32'({ov1, f1, cout1, ovf1, zero1, g1, p1}), 32'd0);
        @(posedge clk); #1;

        //      which name    a         b         s       cin   f         {co,ov,z,g,p}
        issue(0, "add",  16'h1234, 16'h0FFF, 3'b011, 1'b0, 16'h2233, 5'b00000, 1'b1); drain("add");
        issue(0, "amb",  16'h0001, 16'h0002, 3'b010, 1'b1, 16'hFFFF, 5'b00000, 1'b1); drain("amb");
        issue(0, "bma",  16'h0001, 16'h0002, 3'b001, 1'b1, 16'h0001, 5'b10010, 1'b1); drain("bma");
        issue(0, "ovf",  16'h7FFF, 16'h0001, 3'b011, 1'b0, 16'h8000, 5'b01000, 1'b1); drain("ovf");
        issue(0, "clr",  16'h7FFF, 16'h0001, 3'b000, 1'b0, 16'h0000, 5'b00100, 1'b1); drain("clr");
        issue(0, "xor",  16'hF0F0, 16'hFF00, 3'b100, 1'b1, 16'h0FF0, 5'b00000, 1'b1); drain("xor");
        issue(0, "or",   16'hF0F0, 16'hFF00, 3'b101, 1'b1, 16'hFFF0, 5'b00000, 1'b1); drain("or");
        issue(0, "and",  16'hF0F0, 16'hFF00, 3'b110, 1'b1, 16'hF000, 5'b00000, 1'b1); drain("and");
        issue(0, "set",  16'h0000, 16'h0000, 3'b111, 1'b0, 16'hFFFF, 5'b00000, 1'b1); drain("set");
        issue(0, "prop", 16'hFFFF, 16'h0000, 3'b011, 1'b1, 16'h0000, 5'b10101, 1'b1); drain("prop");

        // Back-pressure: hold DONE for three cycles, then consume and accept together.
        or0 = 1'b0;
        issue(0, "stall", 16'h8001, 16'h8001, 3'b011, 1'b0, 16'h0002, 5'b11010, 1'b1);
        n = 0;
        while (ov0 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall.out_valid", 32'(ov0), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("stall.hold_f", 32'(f0), 32'h0002);
            chk("stall.hold_flags", 32'({cout0, ovf0, zero0, g0, p0}), 32'b11010);
            chk("stall.hold_valid_ready", 32'({ov0, ir0}), 32'b10);
            @(posedge clk); #1;
        end
        or0 = 1'b1;
        #1;
        chk("b2b.in_ready", 32'(ir0), 32'd1);
        issue(0, "b2b", 16'h0010, 16'h0100, 3'b001, 1'b1, 16'h00F0, 5'b10010, 1'b1);
        @(negedge clk);
        chk("b2b.no_bubble", 32'({ov0, ir0}), 32'b00);
        @(posedge clk); #1;
        drain("b2b");

        // Reset during RUN cycle 2 must discard the operation.
        issue(0, "abort", 16'h1111, 16'h1111, 3'b011, 1'b0, 16'h0000, 5'b00000, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort.in_ready", 32'(ir0), 32'd1);
        chk("abort.out_valid", 32'(ov0), 32'd0);
        chk("abort.f", 32'(f0), 32'd0);
        chk("abort.flags", 32'({cout0, ovf0, zero0, g0, p0}), 32'd0);
        repeat (8) @(posedge clk);
        #1;

        issue(0, "post", 16'h00FF, 16'h0001, 3'b011, 1'b0, 16'h0100, 5'b00000, 1'b1); drain("post");

        issue(1, "s1add", 16'h000F, 16'h0001, 3'b011, 1'b0, 16'h0000, 5'b10110, 1'b1);
        drain("s1add");
        issue(1, "s1amb", 16'h0003, 16'h0005, 3'b010, 1'b1, 16'h000E, 5'b00000, 1'b1);
        drain("s1amb");

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
